modulud: RTL and testbench



---
 rtl/checksum_pkg.sv | 25 ++
 rtl/modulud_step.sv | 35 +++
 rtl/modulud.sv | 157 +++++++++++++++
 tb/tb_modulud.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/checksum_pkg.sv
// ---------------------------------------------------------------------------
// checksum_pkg
// Shared definitions for the checksum datapath and its modulo reduction unit.
//   DEFAULT_WIDTH : default operand/result width of the modulo unit
//   MOD_BASE      : Adler-style modulus used by checksum consumers
//   state_e       : control states of the sequential modulo unit
//   cnt_bits()    : width of a counter indexing WIDTH bit positions
// ---------------------------------------------------------------------------
package checksum_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int MOD_BASE      = 65521;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_ZERO = 2'd2
  } state_e;

  // At least one bit, so a WIDTH of 1 still yields a legal counter.
  function automatic int cnt_bits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/modulud_step.sv
// ---------------------------------------------------------------------------
// modulud_step
// One combinational restoring-division stage: shifts the next dividend bit
// into the partial remainder and subtracts the divisor if it fits.
//   rem_i     : partial remainder entering the stage (always < divisor_i)
//   bit_i     : next dividend bit, MSB first
//   divisor_i : divisor (non-zero whenever the result is used)
//   rem_o     : partial remainder leaving the stage
//   q_o       : quotient bit produced by this stage
// ---------------------------------------------------------------------------
module modulud_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  // The trial value is one bit wider than the operands so the shift
  // never overflows.
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  assign trial = {rem_i, bit_i};
  assign q_o   = (trial >= {1'b0, divisor_i});

  // When the subtraction is taken, trial - divisor < divisor, so the
  // difference always fits in WIDTH bits and the low-bit subtraction
  // (modulo 2^WIDTH) is exact.
  assign diff  = trial[WIDTH-1:0] - divisor_i;
  assign rem_o = q_o ? diff : trial[WIDTH-1:0];

endmodule

// File: rtl/modulud.sv
// ---------------------------------------------------------------------------
// modulud
// Sequential unsigned divide/modulo unit using restoring shift-subtract, one
// quotient bit per clock. One request in flight; valid/ready on the input
// side, a single-cycle out_valid pulse on the output side.
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : request; operands sampled when in_valid && in_ready
//   in_ready     : high only while idle
//   dividend     : unsigned numerator
//   divisor      : unsigned modulus
//   out_valid    : one-cycle pulse, quotient/result/div_by_zero valid
//   quotient     : floor(dividend / divisor), all-ones on divide by zero
//   result       : dividend mod divisor, dividend on divide by zero
//   div_by_zero  : set alongside out_valid when the divisor was zero
// Latency: WIDTH clocks after acceptance, or 1 clock for a zero divisor.
// Outputs hold their last completed values until the next completion.
// ---------------------------------------------------------------------------
module modulud
  import checksum_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_bits(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quo_shifted;

  // Dividend bits are consumed MSB first, selected directly by the counter.
  modulud_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[cnt_q]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // Partial quotient with the current stage's bit appended at the LSB.
  generate
    if (WIDTH > 1) begin : g_shift
      assign quo_shifted = {quo_q[WIDTH-2:0], step_q};
    end else begin : g_shift1
      assign quo_shifted = step_q;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    quotient_d  = quotient_q;
    result_d    = result_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CNT_LAST;
          state_d = (divisor != '0) ? BUSY : DONE_ZERO;
        end
      end

      BUSY: begin
        rem_d = step_rem;
        quo_d = quo_shifted;
        if (cnt_q == '0) begin
          quotient_d  = quo_shifted;
          result_d    = step_rem;
          dbz_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE_ZERO: begin
        quotient_d  = '1;
        result_d    = dvd_q;
        dbz_d       = 1'b1;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      result_q    <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      result_q    <= result_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_modulud.sv
// ---------------------------------------------------------------------------
// tb_modulud
// Directed and randomized stimulus for modulud. Inputs change and outputs are
// sampled on the falling clock edge; the design acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_modulud;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic [15:0] quotient;
  logic [15:0] result;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  // Last completed outputs, which must stay displayed until the next completion.
  logic [15:0] prev_q = 16'h0;
  logic [15:0] prev_r = 16'h0;
  logic        prev_z = 1'b0;

  modulud #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .quotient    (quotient),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request at the current falling edge (design must be idle) and
  // returns at the falling edge where out_valid is seen.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input string tag);
    logic [15:0] eq;
    logic [15:0] er;
    logic        ez;
    int          lat;
    int          n;
    if (b == 16'd0) begin
      eq = 16'hFFFF; er = a; ez = 1'b1; lat = 1;
    end else begin
      eq = a / b; er = a % b; ez = 1'b0; lat = 16;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    chk({tag, ".in_ready_accept"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = b + 16'd1;
    n = 0;
    chk({tag, ".in_ready_busy"}, {31'd0, in_ready}, 32'd0);
    chk({tag, ".no_early_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".hold_quotient"}, {16'd0, quotient}, {16'd0, prev_q});
    chk({tag, ".hold_result"}, {16'd0, result}, {16'd0, prev_r});
    chk({tag, ".hold_dbz"}, {31'd0, div_by_zero}, {31'd0, prev_z});
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".quotient"}, {16'd0, quotient}, {16'd0, eq});
    chk({tag, ".result"}, {16'd0, result}, {16'd0, er});
    chk({tag, ".div_by_zero"}, {31'd0, div_by_zero}, {31'd0, ez});
    chk({tag, ".in_ready_done"}, {31'd0, in_ready}, 32'd1);
    $display("op %s: %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", tag, a, b,
             quotient, result, div_by_zero, n);
    prev_q = eq;
    prev_r = er;
    prev_z = ez;
  endtask

  initial begin
    int          n;
    int          pulses;
    int          mode;
    logic [15:0] ra;
    logic [15:0] rb;

    rst      = 1'b1;
    in_valid = 1'b0;
    dividend = 16'd0;
    divisor  = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset.quotient", {16'd0, quotient}, 32'd0);
    chk("reset.result", {16'd0, result}, 32'd0);
    chk("reset.div_by_zero", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;

    run_op(16'd52, 16'd50, "52_50");

    // Abort an operation with reset; nothing may complete afterwards.
    dividend = 16'd5655;
    divisor  = 16'd5000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort.in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort.quotient", {16'd0, quotient}, 32'd0);
    chk("abort.result", {16'd0, result}, 32'd0);
    chk("abort.div_by_zero", {31'd0, div_by_zero}, 32'd0);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    chk("abort.no_pulse", pulses, 0);
    $display("op abort: reset during 5655 / 5000, pulses=%0d", pulses);
    prev_q = 16'd0;
    prev_r = 16'd0;
    prev_z = 1'b0;

    // Back-to-back: each call issues in the previous out_valid cycle.
    run_op(16'd500, 16'd400, "500_400");
    run_op(16'd5655, 16'd5000, "5655_5000");
    run_op(16'd65535, 16'd65521, "65535_65521");
    run_op(16'd1000, 16'd7, "1000_7");
    run_op(16'd65535, 16'd1, "65535_1");
    run_op(16'd1234, 16'd0, "1234_0");
    run_op(16'd10, 16'd3, "10_3");
    run_op(16'd3, 16'd10, "3_10");
    run_op(16'd777, 16'd777, "777_777");
    run_op(16'd0, 16'd5, "0_5");
    run_op(16'd65535, 16'd65535, "ffff_ffff");
    run_op(16'd0, 16'd0, "0_0");

    // in_valid held with changing operands while busy: only the first
    // request completes, with exactly one pulse.
    dividend = 16'd1000;
    divisor  = 16'd7;
    in_valid = 1'b1;
    chk("hold.in_ready_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    n = -1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (k < 10) begin
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          chk("hold.latency", n, 16);
          chk("hold.quotient", {16'd0, quotient}, 32'd142);
          chk("hold.result", {16'd0, result}, 32'd6);
          chk("hold.div_by_zero", {31'd0, div_by_zero}, 32'd0);
        end
      end
    end
    chk("hold.pulses", pulses, 1);
    $display("op hold: 1000 / 7 with in_valid held, pulses=%0d", pulses);
    prev_q = 16'd142;
    prev_r = 16'd6;
    prev_z = 1'b0;

    // Randomized operands against the native / and % operators.
    for (int i = 0; i < 1000; i++) begin
      mode = int'($urandom_range(0, 9));
      ra   = 16'($urandom);
      if (mode == 0)      rb = 16'd0;
      else if (mode <= 3) rb = 16'($urandom_range(1, 16));
      else                rb = 16'($urandom);
      run_op(ra, rb, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
